// File: rtl/mem_access_unit.sv
// Load/store unit between a core and a byte-addressed, big-endian data RAM.
// Optional MEM_ACCESS_ALIGN_CHECK_EN makes misaligned half/word accesses fault.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_tag,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_tag,
  output logic        resp_fault,
  output logic [2:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned AW = 33;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        accept_c, finish_c;
  logic        lat_store, lat_unsigned, lat_fault;
  logic [1:0]  lat_size;
  logic [4:0]  lat_tag;
  logic [2:0]  nbytes_c;
  logic [2:0]  we_enc_c;
  logic [AW-1:0] last_byte_c;
  logic        misalign_c, fault_c;
  logic [31:0] ext_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        finish_c = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  // Size decode: byte count and one-hot strobe ([0] word, [1] half, [2] byte)
  always_comb begin
    nbytes_c = 3'd4;
    we_enc_c = 3'b000;
    case (req_size)
      2'd0: begin nbytes_c = 3'd1; we_enc_c = 3'b100; end
      2'd1: begin nbytes_c = 3'd2; we_enc_c = 3'b010; end
      2'd2: begin nbytes_c = 3'd4; we_enc_c = 3'b001; end
      default: begin nbytes_c = 3'd4; we_enc_c = 3'b000; end
    endcase
  end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign_c = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // 33-bit end address so a wrap past 0xFFFFFFFF still faults
  assign last_byte_c = {1'b0, req_addr} + AW'(nbytes_c) - AW'(1);
  assign fault_c     = (last_byte_c > (AW'(MEM_BYTES) - AW'(1))) ||
                       (req_size == 2'd3) || misalign_c;

  // Big-endian extraction: the addressed byte sits in the top lane
  always_comb begin
    ext_c = ram_rdata;
    case (lat_size)
      2'd0:    ext_c = {{24{~lat_unsigned & ram_rdata[31]}}, ram_rdata[31:24]};
      2'd1:    ext_c = {{16{~lat_unsigned & ram_rdata[31]}}, ram_rdata[31:16]};
      default: ext_c = ram_rdata;
    endcase
  end

  // Request latch, RAM drive and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_store    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_fault    <= 1'b0;
      lat_size     <= 2'd0;
      lat_tag      <= 5'd0;
      ram_we       <= 3'b000;
      ram_addr     <= 32'd0;
      ram_wdata    <= 32'd0;
      resp_rdata   <= 32'd0;
      resp_tag     <= 5'd0;
      resp_fault   <= 1'b0;
    end else begin
      ram_we <= 3'b000;
      if (accept_c) begin
        lat_store    <= req_store;
        lat_unsigned <= req_unsigned;
        lat_fault    <= fault_c;
        lat_size     <= req_size;
        lat_tag      <= req_tag;
        ram_addr     <= req_addr;
        ram_wdata    <= req_wdata;
        if (req_store && !fault_c) ram_we <= we_enc_c;
      end
      if (finish_c) begin
        resp_rdata <= (lat_store || lat_fault) ? 32'd0 : ext_c;
        resp_tag   <= lat_tag;
        resp_fault <= lat_fault;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a big-endian byte RAM model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_tag = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_tag;
  logic        resp_fault;
  logic [2:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  mem_access_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_fault(resp_fault),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model
  logic [7:0]  mem [0:4095];
  logic [11:0] a0, a1, a2, a3;
  assign a0 = ram_addr[11:0];
  assign a1 = a0 + 12'd1;
  assign a2 = a0 + 12'd2;
  assign a3 = a0 + 12'd3;
  assign ram_rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};

  always @(posedge clk) begin
    if (ram_we[0]) begin
      mem[a0] <= ram_wdata[31:24]; mem[a1] <= ram_wdata[23:16];
      mem[a2] <= ram_wdata[15:8];  mem[a3] <= ram_wdata[7:0];
    end else if (ram_we[1]) begin
      mem[a0] <= ram_wdata[15:8];  mem[a1] <= ram_wdata[7:0];
    end else if (ram_we[2]) begin
      mem[a0] <= ram_wdata[7:0];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  tag;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  logic [2:0] last_we = 3'b000;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each completed response against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && ram_we != 3'b000) begin
      we_cnt++;
      last_we = ram_we;
    end
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_tag", 32'(resp_tag), 32'(e.tag));
        chk("resp_fault", 32'(resp_fault), 32'(e.fault));
      end
    end
  end

  // Called just after a posedge; returns just after the accepting edge
  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg,
                       input logic [31:0] erd, input logic ef, input bit push);
    int n;
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; req_tag = tg;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{erd, tg, ef});
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0; req_store = ~st; req_size = 2'd3;
    req_addr = 32'hFFFF_FFF0; req_wdata = 32'hDEAD_BEEF; req_tag = 5'd31;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  int we0;
  int hs_cyc;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    // Reset values
    #3;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_tag_fault", {26'd0, resp_tag, resp_fault}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Word store then word load
    we0 = we_cnt;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 5'd1, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd2, 32'h1122_3344, 1'b0, 1'b1);
    drain();
    chk("word_we_count", 32'(we_cnt - we0), 32'd1);
    chk("word_we_kind", 32'(last_we), 32'b001);

    // Byte loads with sign/zero extension
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 5'd3, 32'h0000_0044, 1'b0, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 32'h30, 32'hAAAA_AA80, 5'd4, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 32'h30, 32'd0, 5'd5, 32'hFFFF_FF80, 1'b0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h30, 32'd0, 5'd6, 32'h0000_0080, 1'b0, 1'b1);
    drain();
    chk("byte_mem", {mem[12'h30], mem[12'h31], 16'd0}, 32'h8000_0000);

    // Half store/load with latency check
    issue(1'b1, 2'd1, 1'b0, 32'h20, 32'h1234_BEEF, 5'd7, 32'd0, 1'b0, 1'b1);
    drain();
    chk("half_we_kind", 32'(last_we), 32'b010);
    issue(1'b0, 2'd1, 1'b0, 32'h20, 32'd0, 5'd8, 32'hFFFF_BEEF, 1'b0, 1'b1);
    chk("lat_n1_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n2_valid", 32'(resp_valid), 32'd1);
    issue(1'b0, 2'd1, 1'b1, 32'h20, 32'd0, 5'd9, 32'h0000_BEEF, 1'b0, 1'b1);
    drain();

    // Range faults and the last legal word
    we0 = we_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'hFFE, 32'd0, 5'd10, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd11, 32'd0, 1'b1, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'hFFE, 32'h0BAD_0BAD, 5'd12, 32'd0, 1'b1, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFE_F00D, 5'd13, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'hFFC, 32'd0, 5'd14, 32'hCAFE_F00D, 1'b0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h0, 32'd0, 5'd15, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'hFFF, 32'd0, 5'd16, 32'h0000_000D, 1'b0, 1'b1);
    drain();
    chk("fault_we_count", 32'(we_cnt - we0), 32'd1);

    // Backpressure: response held, next request waits
    resp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd17, 32'h1122_3344, 1'b0, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
    req_addr = 32'h10; req_tag = 5'd18;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_resp_hold", {resp_valid, resp_fault, resp_tag, resp_rdata[24:0]},
          {1'b1, 1'b0, 5'd17, 25'h122_3344});
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    hs_cyc = cyc;
    chk("bp_ready_after_hs", 32'(req_ready), 32'd1);
    issue(1'b0, 2'd0, 1'b1, 32'h10, 32'd0, 5'd18, 32'h0000_0011, 1'b0, 1'b1);
    chk("bp_accept_cycle", 32'(acc_cyc - hs_cyc), 32'd1);
    drain();

    // Misaligned word store
    we0 = we_cnt;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    issue(1'b1, 2'd2, 1'b0, 32'h22, 32'hA1B2_C3D4, 5'd19, 32'd0, 1'b1, 1'b1);
    drain();
    chk("misalign_no_we", 32'(we_cnt - we0), 32'd0);
    chk("misalign_mem", {mem[12'h22], mem[12'h23], mem[12'h24], mem[12'h25]}, 32'd0);
`else
    issue(1'b1, 2'd2, 1'b0, 32'h22, 32'hA1B2_C3D4, 5'd19, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h22, 32'd0, 5'd20, 32'hA1B2_C3D4, 1'b0, 1'b1);
    drain();
    chk("misalign_we", 32'(we_cnt - we0), 32'd1);
    chk("misalign_mem", {mem[12'h22], mem[12'h23], mem[12'h24], mem[12'h25]}, 32'hA1B2_C3D4);
`endif

    // Reset during ACCESS drops the write and the response
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h5566_7788, 5'd21, 32'd0, 1'b0, 1'b0);
    chk("access_we", 32'(ram_we), 32'b001);
    rst_n = 1'b0;
    #1;
    chk("rst_access_we", 32'(ram_we), 32'd0);
    chk("rst_access_valid", 32'(resp_valid), 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_no_resp", 32'(resp_valid), 32'd0);
    chk("rst_no_write", {mem[12'h40], mem[12'h41], mem[12'h42], mem[12'h43]}, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd22, 32'h1122_3344, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
